// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and request types for the ALU issue path.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } opcode_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        opcode_t    opcode;
    } alu_req_t;

endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: DEPTH-entry synchronous FIFO of ALU requests; head reads zero when empty.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  logic     pop_i,
    input  alu_req_t din_i,
    output alu_req_t head_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int AW = $clog2(DEPTH);

    alu_req_t        mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     cnt_q;
    logic            do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop) rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers ALU requests, drives the external ALU from the FIFO head,
// registers results for a valid/ready consumer and counts completed operations.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [1:0]       in_opcode,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [7:0]       alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_result,
    output logic [1:0]       out_opcode,
    output logic [CNT_W-1:0] op_count
);
    alu_req_t         req, head;
    logic             full, empty, push, cap, done;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_result_q, out_result_d;
    logic [1:0]       out_opcode_q, out_opcode_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    assign req      = '{a: in_a, b: in_b, opcode: opcode_t'(in_opcode)};
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign cap      = !empty && (!out_valid_q || out_ready);
    assign done     = out_valid_q && out_ready;

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (cap),
        .din_i   (req),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign alu_a      = head.a;
    assign alu_b      = head.b;
    assign alu_opcode = head.opcode;

    always_comb begin
        out_valid_d  = cap ? 1'b1 : (done ? 1'b0 : out_valid_q);
        out_result_d = cap ? alu_result : out_result_q;
        out_opcode_d = cap ? head.opcode : out_opcode_q;
        op_count_d   = op_count_q + CNT_W'(done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_opcode_q <= '0;
            op_count_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_opcode_q <= out_opcode_d;
            op_count_q   <= op_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_opcode = out_opcode_q;
    assign op_count   = op_count_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of the issue stage with a behavioural ALU attached.
module tb_alu_issue_stage;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
    logic [1:0] in_opcode, alu_opcode, out_opcode;
    logic [3:0] op_count;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (alu_opcode)
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a ^ alu_b;
            2'b10:   alu_result = alu_a + alu_b;
            default: alu_result = alu_a - alu_b;
        endcase
    end

    alu_issue_stage #(.DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_opcode(out_opcode), .op_count(op_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_opcode = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_opcode = '0;
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low got %b exp 0", in_ready); end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_high got %b exp 1", in_ready); end
        n_checks++;
        if ({out_valid, out_result, out_opcode, op_count} !== 15'h0)
            begin n_fail++; $display("FAIL reset_outputs got v=%b r=%h o=%h c=%h exp all 0", out_valid, out_result, out_opcode, op_count); end
        n_checks++;
        if ({alu_a, alu_b, alu_opcode} !== 18'h0)
            begin n_fail++; $display("FAIL reset_alu_drive got a=%h b=%h op=%h exp 0", alu_a, alu_b, alu_opcode); end
    endtask

    task automatic test_single_op();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'hDA; in_b = 8'hAA; in_opcode = 2'b00;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency got out_valid=%b exp 0", out_valid); end
        n_checks++;
        if (alu_a !== 8'hDA || alu_b !== 8'hAA) begin n_fail++; $display("FAIL single_head got a=%h b=%h exp DA AA", alu_a, alu_b); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 8'h8A || out_opcode !== 2'b00)
            begin n_fail++; $display("FAIL single_result got v=%b r=%h o=%h exp 1 8A 0", out_valid, out_result, out_opcode); end
        tick();
        n_checks++;
        if (op_count !== 4'd1 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL single_count got c=%0d v=%b exp 1 0", op_count, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_r [4] = '{8'h8A, 8'h70, 8'h84, 8'h30};
        do_reset();
        out_ready = 1'b1;
        in_a = 8'hDA; in_b = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            in_valid = i < 4;
            in_opcode = 2'(i);
            tick();
            if (i == 0) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_first_idle got %b exp 0", out_valid); end
            end else if (i <= 4) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_result !== exp_r[i-1] || out_opcode !== 2'(i-1))
                    begin n_fail++; $display("FAIL b2b_result%0d got v=%b r=%h o=%h exp 1 %h %0d", i-1, out_valid, out_result, out_opcode, exp_r[i-1], i-1); end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0 || op_count !== 4'd4)
                    begin n_fail++; $display("FAIL b2b_done got v=%b c=%0d exp 0 4", out_valid, op_count); end
            end
        end
    endtask

    task automatic test_backpressure_full();
        int idx = 0;
        logic acc;
        do_reset();
        in_b = 8'h20; in_opcode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 8'hF0 + 8'(i);
            tick();
        end
        in_a = 8'hF5;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 8'h10)
                begin n_fail++; $display("FAIL bp_stall%0d got rdy=%b v=%b r=%h exp 0 1 10", i, in_ready, out_valid, out_result); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_bypass got in_ready=%b exp 0", in_ready); end
        for (int c = 0; c < 30 && idx < 6; c++) begin
            if (out_valid) begin
                n_checks++;
                if (out_result !== 8'h10 + 8'(idx))
                    begin n_fail++; $display("FAIL bp_order%0d got %h exp %h", idx, out_result, 8'h10 + 8'(idx)); end
                idx++;
            end
            acc = in_valid && in_ready;
            tick();
            if (c == 0) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_accept_next got in_ready=%b exp 1", in_ready); end
            end
            if (acc) in_valid = 1'b0;
        end
        n_checks++;
        if (idx !== 6) begin n_fail++; $display("FAIL bp_count got %0d results exp 6", idx); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || op_count !== 4'd6)
            begin n_fail++; $display("FAIL bp_no_dup got v=%b c=%0d exp 0 6", out_valid, op_count); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02; in_opcode = 2'b10;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 8'h40 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || op_count !== 4'd1)
            begin n_fail++; $display("FAIL mid_pre got v=%b c=%0d exp 1 1", out_valid, op_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || op_count !== 4'd0 || in_ready !== 1'b1 || alu_a !== 8'h00)
            begin n_fail++; $display("FAIL mid_post got v=%b c=%0d rdy=%b a=%h exp 0 0 1 00", out_valid, op_count, in_ready, alu_a); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale%0d got out_valid=%b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            {in_a, in_b, in_opcode} = (i == 16) ? {8'h00, 8'h01, 2'b11} : {8'hFF, 8'hFF, 2'b00};
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 8'hFF || out_opcode !== 2'b11)
            begin n_fail++; $display("FAIL wrap_sub got v=%b r=%h o=%h exp 1 FF 3", out_valid, out_result, out_opcode); end
        n_checks++;
        if (op_count !== 4'd0) begin n_fail++; $display("FAIL wrap_16 got %0d exp 0", op_count); end
        tick();
        n_checks++;
        if (op_count !== 4'd1 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL wrap_17 got c=%0d v=%b exp 1 0", op_count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_backpressure_full();
        test_reset_mid_op();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
